// File: rtl/lcd_init_ctrl.sv
// HD44780-style LCD controller: runs a ROM-driven init sequence after power-up, then
// forwards single user bytes over the same SETUP/E_HIGH/HOLD/WAIT bus timing.
module lcd_init_ctrl #(
  parameter int unsigned INST_NUM      = 14,
  parameter int unsigned PWR_WAIT_CYC  = 1_500_000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned E_HIGH_CYC    = 30,
  parameter int unsigned CMD_WAIT_CYC  = 4_000,
  parameter int unsigned LONG_WAIT_CYC = 160_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       reinit,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  typedef enum logic [2:0] {
    StPwrWait,
    StFetch,
    StSetup,
    StEHigh,
    StHold,
    StWait,
    StReady
  } state_e;

  localparam logic [23:0] PwrLast   = 24'(PWR_WAIT_CYC - 1);
  localparam logic [23:0] SetupLast = 24'(SETUP_CYC - 1);
  localparam logic [23:0] EHighLast = 24'(E_HIGH_CYC - 1);
  localparam logic [23:0] CmdLast   = 24'(CMD_WAIT_CYC - 1);
  localparam logic [23:0] LongLast  = 24'(LONG_WAIT_CYC - 1);
  localparam logic [3:0]  LastIdx   = 4'(INST_NUM - 1);

  state_e      state_q;
  logic [23:0] cnt_q;
  logic [3:0]  index_q;
  logic        long_cmd;
  logic [23:0] wait_last;

  // Clear display (0x01) and return home (0x02) need the long execution time.
  always_comb begin
    long_cmd  = !lcd_rs && ((lcd_db == 8'h01) || (lcd_db == 8'h02));
    wait_last = long_cmd ? LongLast : CmdLast;
  end

  // index is cleared on entering READY, so the ROM address idles at 0 there.
  assign rom_addr = index_q;
  assign lcd_rw   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StPwrWait;
      cnt_q     <= '0;
      index_q   <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
      init_done <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 24'd1;
      case (state_q)
        StPwrWait: begin
          if (cnt_q == PwrLast) begin
            cnt_q   <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          cnt_q   <= '0;
          lcd_db  <= rom_data;
          lcd_rs  <= 1'b0;
          state_q <= StSetup;
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q   <= '0;
            lcd_e   <= 1'b1;
            state_q <= StEHigh;
          end
        end
        StEHigh: begin
          if (cnt_q == EHighLast) begin
            cnt_q   <= '0;
            lcd_e   <= 1'b0;
            state_q <= StHold;
          end
        end
        StHold: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == wait_last) begin
            cnt_q <= '0;
            if (!init_done && (index_q < LastIdx)) begin
              index_q <= index_q + 4'd1;
              state_q <= StFetch;
            end else begin
              index_q   <= '0;
              init_done <= 1'b1;
              wr_ready  <= 1'b1;
              state_q   <= StReady;
            end
          end
        end
        StReady: begin
          cnt_q <= '0;
          // reinit has priority over a simultaneous user byte.
          if (reinit) begin
            init_done <= 1'b0;
            index_q   <= '0;
            wr_ready  <= 1'b0;
            state_q   <= StPwrWait;
          end else if (wr_valid) begin
            lcd_rs   <= wr_rs;
            lcd_db   <= wr_data;
            wr_ready <= 1'b0;
            state_q  <= StSetup;
          end
        end
        default: begin
          cnt_q   <= '0;
          lcd_e   <= 1'b0;
          state_q <= StPwrWait;
        end
      endcase
    end
  end

endmodule
